// File: rtl/fetch_pkg.sv
// Shared fetch-entry type and default queue geometry for the IF/ID boundary.
package fetch_pkg;
  localparam int FQ_DEPTH   = 4;
  localparam int FQ_ADDR_W  = 32;
  localparam int FQ_INSTR_W = 32;

  typedef struct packed {
    logic [FQ_INSTR_W-1:0] instr;
    logic [FQ_ADDR_W-1:0]  pc;
    logic [FQ_ADDR_W-1:0]  pc_plus4;
    logic                  bp;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH x WIDTH, one write port, read port addressed by a register
// owned by the caller, so the read data depends only on registered state.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 97,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between IF and decode: entries appear one cycle after push, no bypass.
// A full queue still accepts when the head leaves in the same cycle; FLUSH beats everything.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = FQ_DEPTH,
  parameter int ADDR_W  = FQ_ADDR_W,
  parameter int INSTR_W = FQ_INSTR_W,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               FLUSH,
  input  logic               STALL,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [INSTR_W-1:0] Instr_IF,
  input  logic [ADDR_W-1:0]  Instr_PC_IF,
  input  logic [ADDR_W-1:0]  Instr_PC_Plus4_IF,
  input  logic               Branch_prediction_IN,
  output logic               OUT_VALID,
  output logic [INSTR_W-1:0] Instr_OUT,
  output logic [ADDR_W-1:0]  Instr_PC_OUT,
  output logic [ADDR_W-1:0]  Instr_PC_Plus4_OUT,
  output logic               Branch_prediction_OUT,
  output logic [CNT_W-1:0]   COUNT
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               bp;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  entry_t           wr_entry, rd_entry, head;

  assign OUT_VALID = (count_q != '0);
  assign pop       = OUT_VALID && !STALL && !FLUSH;
  assign IN_READY  = (count_q < FULL) || pop;
  assign push      = IN_VALID && IN_READY && !FLUSH;

  assign wr_entry = '{instr: Instr_IF, pc: Instr_PC_IF,
                      pc_plus4: Instr_PC_Plus4_IF, bp: Branch_prediction_IN};

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (AW)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // Storage is never cleared, so stale contents are masked whenever the queue is empty.
  assign head                  = OUT_VALID ? rd_entry : '0;
  assign Instr_OUT             = head.instr;
  assign Instr_PC_OUT          = head.pc;
  assign Instr_PC_Plus4_OUT    = head.pc_plus4;
  assign Branch_prediction_OUT = head.bp;
  assign COUNT                 = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard monitor checking every dequeued entry.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET, FLUSH, STALL, IN_VALID, IN_READY;
  logic [31:0] Instr_IF, Instr_PC_IF, Instr_PC_Plus4_IF;
  logic        Branch_prediction_IN;
  logic        OUT_VALID;
  logic [31:0] Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT;
  logic        Branch_prediction_OUT;
  logic [2:0]  COUNT;

  int total = 0;
  int bad   = 0;
  fetch_entry_t exp_q[$];

  fetch_queue #(.DEPTH(4), .ADDR_W(32), .INSTR_W(32)) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .FLUSH                 (FLUSH),
    .STALL                 (STALL),
    .IN_VALID              (IN_VALID),
    .IN_READY              (IN_READY),
    .Instr_IF              (Instr_IF),
    .Instr_PC_IF           (Instr_PC_IF),
    .Instr_PC_Plus4_IF     (Instr_PC_Plus4_IF),
    .Branch_prediction_IN  (Branch_prediction_IN),
    .OUT_VALID             (OUT_VALID),
    .Instr_OUT             (Instr_OUT),
    .Instr_PC_OUT          (Instr_PC_OUT),
    .Instr_PC_Plus4_OUT    (Instr_PC_Plus4_OUT),
    .Branch_prediction_OUT (Branch_prediction_OUT),
    .COUNT                 (COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drive one IF entry; 'keep' records it as an entry decode must eventually see.
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic bp,
                       input bit keep);
    fetch_entry_t e;
    IN_VALID             = 1'b1;
    Instr_IF             = instr;
    Instr_PC_IF          = pc;
    Instr_PC_Plus4_IF    = pc + 32'd4;
    Branch_prediction_IN = bp;
    if (keep) begin
      e.instr    = instr;
      e.pc       = pc;
      e.pc_plus4 = pc + 32'd4;
      e.bp       = bp;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_in();
    IN_VALID             = 1'b0;
    Instr_IF             = '0;
    Instr_PC_IF          = '0;
    Instr_PC_Plus4_IF    = '0;
    Branch_prediction_IN = 1'b0;
  endtask

  // Monitor: an entry is consumed at the next edge whenever the head is valid and not held.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge CLK);
      if (!RESET && OUT_VALID && !STALL && !FLUSH) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got pc %h expected no entry", Instr_PC_OUT);
        end else begin
          e = exp_q.pop_front();
          chk("pop_instr", 64'(Instr_OUT), 64'(e.instr));
          chk("pop_pc", 64'(Instr_PC_OUT), 64'(e.pc));
          chk("pop_pc4", 64'(Instr_PC_Plus4_OUT), 64'(e.pc_plus4));
          chk("pop_bp", 64'(Branch_prediction_OUT), 64'(e.bp));
        end
      end
    end
  end

  initial begin
    RESET = 1'b1;
    FLUSH = 1'b0;
    STALL = 1'b0;
    idle_in();
    #12;
    chk("rst_count", 64'(COUNT), 64'd0);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_in_ready", 64'(IN_READY), 64'd1);
    chk("rst_instr", 64'(Instr_OUT), 64'd0);
    step();
    RESET = 1'b0;

    // Streaming three entries with decode always accepting.
    drive(32'h0000_0011, 32'h100, 1'b0, 1'b1);
    step();
    chk("s_count1", 64'(COUNT), 64'd1);
    chk("s_valid1", 64'(OUT_VALID), 64'd1);
    drive(32'h0000_0022, 32'h104, 1'b1, 1'b1);
    step();
    chk("s_count2", 64'(COUNT), 64'd1);
    drive(32'h0000_0033, 32'h108, 1'b0, 1'b1);
    step();
    chk("s_count3", 64'(COUNT), 64'd1);
    idle_in();
    step();
    chk("s_count_end", 64'(COUNT), 64'd0);
    chk("s_valid_end", 64'(OUT_VALID), 64'd0);
    chk("s_pc_zero", 64'(Instr_PC_OUT), 64'd0);

    // Stalled fill: fifth push must be refused.
    STALL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(32'hA000_0000 + 32'(i), 32'h200 + 32'(4 * i), i[0], i < 4);
      #1;
      if (i == 4) chk("full_in_ready", 64'(IN_READY), 64'd0);
      step();
    end
    idle_in();
    chk("full_count", 64'(COUNT), 64'd4);
    STALL = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("drain_count", 64'(COUNT), 64'd0);
    chk("drain_q_empty", 64'(exp_q.size()), 64'd0);

    // Full queue with push and pop every cycle; pointers wrap past index 3.
    STALL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(32'hB000_0000 + 32'(i), 32'h300 + 32'(4 * i), 1'b0, 1'b1);
      step();
    end
    STALL = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(32'hC000_0000 + 32'(i), 32'h400 + 32'(4 * i), ~i[0], 1'b1);
      #1;
      chk("wrap_in_ready", 64'(IN_READY), 64'd1);
      step();
      chk("wrap_count", 64'(COUNT), 64'd4);
    end
    idle_in();
    for (int i = 0; i < 5; i++) step();
    chk("wrap_drain_count", 64'(COUNT), 64'd0);

    // Flush with a concurrent push at COUNT==3.
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'hD000_0000 + 32'(i), 32'h500 + 32'(4 * i), 1'b1, 1'b0);
      step();
    end
    chk("pre_flush_count", 64'(COUNT), 64'd3);
    FLUSH = 1'b1;
    drive(32'hEEEE_EEEE, 32'h600, 1'b1, 1'b0);
    step();
    FLUSH = 1'b0;
    STALL = 1'b0;
    idle_in();
    chk("flush_count", 64'(COUNT), 64'd0);
    chk("flush_valid", 64'(OUT_VALID), 64'd0);
    chk("flush_instr", 64'(Instr_OUT), 64'd0);
    chk("flush_pc", 64'(Instr_PC_OUT), 64'd0);
    chk("flush_bp", 64'(Branch_prediction_OUT), 64'd0);
    step();
    chk("flush_stays_empty", 64'(COUNT), 64'd0);

    // Asynchronous reset mid-cycle with two entries held.
    STALL = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(32'hF000_0000 + 32'(i), 32'h700 + 32'(4 * i), 1'b1, 1'b0);
      step();
    end
    idle_in();
    chk("pre_rst_count", 64'(COUNT), 64'd2);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_count", 64'(COUNT), 64'd0);
    chk("arst_valid", 64'(OUT_VALID), 64'd0);
    chk("arst_instr", 64'(Instr_OUT), 64'd0);
    chk("arst_pc", 64'(Instr_PC_OUT), 64'd0);
    chk("arst_bp", 64'(Branch_prediction_OUT), 64'd0);
    #3;
    RESET = 1'b0;
    STALL = 1'b0;
    drive(32'hDEAD_BEEF, 32'h800, 1'b1, 1'b1);
    step();
    idle_in();
    chk("post_rst_count", 64'(COUNT), 64'd1);
    chk("post_rst_bp", 64'(Branch_prediction_OUT), 64'd1);
    step();
    chk("post_rst_drain", 64'(COUNT), 64'd0);
    chk("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
